r200_lsu: RTL and testbench
===========================

R200_LSU -- requirements
Module: r200_lsu

Interface
REQ-001 Parameter: TIMEOUT, default 255, max bus wait cycles per access before error completion.
REQ-002 clk  in  1  single clock, all state rises on posedge.
REQ-003 rst  in  1  asynchronous, active-low reset.
REQ-004 core_req  in  1  mem stage requests an access; held high until core_done.
REQ-005 core_we  in  1  1=store, 0=load.
REQ-006 core_addr  in  32  byte address (ALU result).
REQ-007 core_wdata  in  32  store data (rs2 value).
REQ-008 core_func3  in  3  RV32I width/sign code.
REQ-009 core_stall  out  1  freeze pipeline while access outstanding.
REQ-010 core_done  out  1  one-cycle completion pulse.
REQ-011 core_rdata  out  32  extended load result, valid with core_done.
REQ-012 core_err  out  1  misalign/illegal/timeout flag, valid with core_done.
REQ-013 bus_valid  out  1  request valid.
REQ-014 bus_ready  in  1  slave accepts request.
REQ-015 bus_we, bus_addr[31:0], bus_wstrb[3:0], bus_wdata[31:0]  out  request fields.
REQ-016 bus_rvalid  in  1, bus_rdata  in  32  read response.

Function
REQ-017 FSM states IDLE, REQ, WAIT, DONE; SHALL leave IDLE only on core_req=1.
REQ-018 IDLE: SHALL register addr, we, func3, lane-aligned wdata, wstrb on core_req; legal -> REQ, illegal/misaligned -> DONE with err=1, no bus traffic.
REQ-019 Legal func3: loads 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; stores 000 SB, 001 SH, 010 SW; all others illegal.
REQ-020 Misaligned: halfword with addr[0]=1; word with addr[1:0]!=0.
REQ-021 bus_addr SHALL be {addr[31:2],2'b00}; bus_wstrb SB=0001<<addr[1:0], SH=0011<<addr[1:0], SW=1111, loads 0000.
REQ-022 bus_wdata SHALL replicate byte into all four lanes (SB), halfword into both halves (SH), word unchanged (SW).
REQ-023 REQ: bus_valid=1, fields stable until bus_ready=1; then store -> DONE, load -> WAIT.
REQ-024 WAIT: on bus_rvalid=1 capture bus_rdata -> DONE; bus_rvalid in the same cycle as bus_ready SHALL NOT be sampled.
REQ-025 Load extraction: select byte/half by addr[1:0]; LB/LH sign-extend, LBU/LHU zero-extend, LW pass-through.
REQ-026 Cycle counter SHALL clear on IDLE exit, increment each REQ/WAIT cycle; reaching TIMEOUT -> DONE, err=1, rdata=0, bus_valid dropped.
REQ-027 DONE: core_done=1 one cycle, -> IDLE; next request accepted earliest the following cycle.
REQ-028 core_stall SHALL equal (core_req & state==IDLE) | (state==REQ) | (state==WAIT); 0 in DONE.
REQ-029 bus_rvalid outside WAIT (including late after timeout) SHALL be ignored.
REQ-030 Minimum latency: store 3 cycles req->done (ready immediate); load 4 cycles (rvalid one cycle after ready).
REQ-031 core_rdata, core_err SHALL hold their values until next core_done.

Reset
REQ-032 rst=0 SHALL immediately force IDLE, counter 0, bus_valid=0, core_done=0, core_err=0, core_rdata=0, bus fields 0, regardless of state.
REQ-033 Reset mid-access SHALL abandon the transaction; no core_done issued for it.

Verification
REQ-034 SW addr 0x100 data 0xDEADBEEF, ready immediate -> bus_addr 0x100, wstrb 1111, done after 3 cycles, err 0.
REQ-035 SB addr 0x103 data 0x000000A5 -> wstrb 1000, wdata 0xA5A5A5A5.
REQ-036 LB addr 0x202, rdata 0x1280FF00 -> core_rdata 0xFFFFFF80; LHU addr 0x202 same data -> 0x00001280.
REQ-037 LW addr 0x102 -> no bus_valid, done next cycle with err=1; func3 011 -> same.
REQ-038 LW with bus_rvalid never asserted, TIMEOUT=4 -> err=1, rdata 0 after timeout; late rvalid ignored.
REQ-039 rst low while in WAIT -> all outputs 0, IDLE; next LW completes normally.

Source files
------------

// File: rtl/r200_lsu.sv
// RV32I load/store unit: turns one mem-stage access into a single bus request,
// aligns store data into byte lanes and extends load data, with a per-access timeout.
module r200_lsu #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  // core side
  input  logic        core_req_i,
  input  logic        core_we_i,
  input  logic [31:0] core_addr_i,
  input  logic [31:0] core_wdata_i,
  input  logic [2:0]  core_func3_i,
  output logic        core_stall_o,
  output logic        core_done_o,
  output logic [31:0] core_rdata_o,
  output logic        core_err_o,
  // bus side
  output logic        bus_valid_o,
  input  logic        bus_ready_i,
  output logic        bus_we_o,
  output logic [31:0] bus_addr_o,
  output logic [3:0]  bus_wstrb_o,
  output logic [31:0] bus_wdata_o,
  input  logic        bus_rvalid_i,
  input  logic [31:0] bus_rdata_i
);

  localparam int unsigned CntW = $clog2(TIMEOUT + 2);
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT - 1);

  typedef enum logic [1:0] {StIdle, StReq, StWait, StDone} state_e;

  state_e           state_q, state_d;
  logic [31:0]      addr_q, addr_d;
  logic             we_q, we_d;
  logic [2:0]       func3_q, func3_d;
  logic [31:0]      wdata_q, wdata_d;
  logic [3:0]       wstrb_q, wstrb_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [31:0]      rdata_q, rdata_d;
  logic             err_q, err_d;

  // Request decode on the raw core inputs
  logic        req_legal;
  logic        req_misal;
  logic [3:0]  req_wstrb;
  logic [31:0] req_wdata;

  always_comb begin
    req_legal = 1'b0;
    req_misal = 1'b0;
    req_wstrb = 4'b0000;
    req_wdata = 32'h0;
    case (core_func3_i)
      3'b000: begin
        req_legal = 1'b1;
        if (core_we_i) begin
          req_wstrb = 4'b0001 << core_addr_i[1:0];
          req_wdata = {4{core_wdata_i[7:0]}};
        end
      end
      3'b001: begin
        req_legal = 1'b1;
        req_misal = core_addr_i[0];
        if (core_we_i) begin
          req_wstrb = 4'b0011 << core_addr_i[1:0];
          req_wdata = {2{core_wdata_i[15:0]}};
        end
      end
      3'b010: begin
        req_legal = 1'b1;
        req_misal = |core_addr_i[1:0];
        if (core_we_i) begin
          req_wstrb = 4'b1111;
          req_wdata = core_wdata_i;
        end
      end
      3'b100: req_legal = ~core_we_i;
      3'b101: begin
        req_legal = ~core_we_i;
        req_misal = core_addr_i[0];
      end
      default: req_legal = 1'b0;
    endcase
  end

  // Load extraction from the response word using the captured offset
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_data;

  always_comb begin
    ld_byte = bus_rdata_i[{addr_q[1:0], 3'b000} +: 8];
    ld_half = bus_rdata_i[{addr_q[1], 4'b0000} +: 16];
    case (func3_q)
      3'b000:  ld_data = {{24{ld_byte[7]}}, ld_byte};
      3'b001:  ld_data = {{16{ld_half[15]}}, ld_half};
      3'b100:  ld_data = {24'h0, ld_byte};
      3'b101:  ld_data = {16'h0, ld_half};
      default: ld_data = bus_rdata_i;
    endcase
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    we_d    = we_q;
    func3_d = func3_q;
    wdata_d = wdata_q;
    wstrb_d = wstrb_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    err_d   = err_q;

    unique case (state_q)
      StIdle: begin
        if (core_req_i) begin
          addr_d  = core_addr_i;
          we_d    = core_we_i;
          func3_d = core_func3_i;
          wdata_d = req_wdata;
          wstrb_d = req_wstrb;
          cnt_d   = '0;
          if (!req_legal || req_misal) begin
            err_d   = 1'b1;
            rdata_d = 32'h0;
            state_d = StDone;
          end else begin
            state_d = StReq;
          end
        end
      end
      StReq: begin
        cnt_d = cnt_q + CntW'(1);
        if (bus_ready_i) begin
          if (we_q) begin
            err_d   = 1'b0;
            rdata_d = 32'h0;
            state_d = StDone;
          end else begin
            state_d = StWait;
          end
        end else if (cnt_q == CntLast) begin
          err_d   = 1'b1;
          rdata_d = 32'h0;
          state_d = StDone;
        end
      end
      StWait: begin
        cnt_d = cnt_q + CntW'(1);
        if (bus_rvalid_i) begin
          err_d   = 1'b0;
          rdata_d = ld_data;
          state_d = StDone;
        end else if (cnt_q == CntLast) begin
          err_d   = 1'b1;
          rdata_d = 32'h0;
          state_d = StDone;
        end
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      addr_q  <= 32'h0;
      we_q    <= 1'b0;
      func3_q <= 3'b000;
      wdata_q <= 32'h0;
      wstrb_q <= 4'b0000;
      cnt_q   <= '0;
      rdata_q <= 32'h0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      func3_q <= func3_d;
      wdata_q <= wdata_d;
      wstrb_q <= wstrb_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  assign core_stall_o = (core_req_i && (state_q == StIdle)) ||
                        (state_q == StReq) || (state_q == StWait);
  assign core_done_o  = (state_q == StDone);
  assign core_rdata_o = rdata_q;
  assign core_err_o   = err_q;

  assign bus_valid_o  = (state_q == StReq);
  assign bus_we_o     = we_q;
  assign bus_addr_o   = {addr_q[31:2], 2'b00};
  assign bus_wstrb_o  = wstrb_q;
  assign bus_wdata_o  = wdata_q;

endmodule

// File: tb/tb_r200_lsu.sv
// Bench for r200_lsu: directed cases plus randomized accesses checked against
// an arithmetic model of lane selection, extension and completion timing.
module tb_r200_lsu;

  localparam int TO = 4;

  logic        clk;
  logic        rst_n;
  logic        core_req, core_we;
  logic [31:0] core_addr, core_wdata;
  logic [2:0]  core_func3;
  logic        core_stall, core_done, core_err;
  logic [31:0] core_rdata;
  logic        bus_valid, bus_ready, bus_we, bus_rvalid;
  logic [31:0] bus_addr, bus_wdata, bus_rdata;
  logic [3:0]  bus_wstrb;

  int tests = 0;
  int fails = 0;

  r200_lsu #(.TIMEOUT(TO)) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .core_req_i   (core_req),
    .core_we_i    (core_we),
    .core_addr_i  (core_addr),
    .core_wdata_i (core_wdata),
    .core_func3_i (core_func3),
    .core_stall_o (core_stall),
    .core_done_o  (core_done),
    .core_rdata_o (core_rdata),
    .core_err_o   (core_err),
    .bus_valid_o  (bus_valid),
    .bus_ready_i  (bus_ready),
    .bus_we_o     (bus_we),
    .bus_addr_o   (bus_addr),
    .bus_wstrb_o  (bus_wstrb),
    .bus_wdata_o  (bus_wdata),
    .bus_rvalid_i (bus_rvalid),
    .bus_rdata_i  (bus_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic bit m_legal(input bit we, input logic [2:0] f3);
    if (we) return f3 <= 3'd2;
    return f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
  endfunction

  function automatic int m_size(input logic [2:0] f3);
    return 1 << f3[1:0];
  endfunction

  function automatic logic [3:0] m_wstrb(input logic [2:0] f3, input logic [31:0] a);
    int mask;
    mask = ((1 << m_size(f3)) - 1) << (a % 4);
    return 4'(mask);
  endfunction

  function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] d);
    logic [31:0] r;
    int s;
    s = m_size(f3);
    r = 32'h0;
    for (int i = 0; i < 4; i++) r[8*i +: 8] = d[8*(i % s) +: 8];
    return r;
  endfunction

  function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] a,
                                         input logic [31:0] d);
    logic [31:0] v, mask;
    int s;
    s = m_size(f3);
    if (s == 4) return d;
    mask = (32'd1 << (8 * s)) - 32'd1;
    v = (d >> (8 * (a % 4))) & mask;
    if (!f3[2] && v[8*s-1]) v = v | ~mask;
    return v;
  endfunction

  // rd/rv: cycles of delay before ready / rvalid; negative means never.
  task automatic access(input bit we, input logic [31:0] addr, input logic [31:0] wd,
                        input logic [2:0] f3, input int rd, input int rv,
                        input logic [31:0] rdata);
    bit illegal, tmo, accepted, done_seen;
    int need, exp_done, exp_valid, valid_cnt, wait_cnt;
    logic [31:0] exp_rd;
    bit exp_err;
    illegal = !m_legal(we, f3) || ((addr % m_size(f3)) != 0);
    tmo = 1'b0;
    if (illegal) begin
      exp_done = 1; exp_err = 1'b1; exp_rd = 32'h0; exp_valid = 0;
    end else begin
      if (rd < 0) need = TO + 1;
      else need = rd + 1 + (we ? 0 : ((rv < 0) ? TO + 1 : rv + 1));
      tmo = need > TO;
      exp_done = 1 + (tmo ? TO : need);
      exp_err = tmo;
      exp_rd = (tmo || we) ? 32'h0 : m_load(f3, addr, rdata);
      exp_valid = (rd < 0 || rd + 1 > TO) ? TO : rd + 1;
    end
    accepted = 1'b0; done_seen = 1'b0; valid_cnt = 0; wait_cnt = 0;
    @(posedge clk); #1;
    core_req = 1'b1; core_we = we; core_addr = addr; core_wdata = wd; core_func3 = f3;
    for (int c = 0; c < 60 && !done_seen; c++) begin
      @(negedge clk);
      bus_ready = 1'b0; bus_rvalid = 1'b0; bus_rdata = $urandom;
      if (c == 0) chk("stall_on_req", core_stall, 1);
      if (bus_valid) begin
        valid_cnt++;
        chk("bus_addr", bus_addr, {addr[31:2], 2'b00});
        chk("bus_we", bus_we, we);
        chk("bus_wstrb", bus_wstrb, we ? m_wstrb(f3, addr) : 4'b0000);
        if (we) chk("bus_wdata", bus_wdata, m_wdata(f3, wd));
        if (rd >= 0 && valid_cnt == rd + 1) begin
          bus_ready = 1'b1; bus_rvalid = 1'b1; accepted = 1'b1;  // same-cycle rvalid is junk
        end
      end else if (accepted && !core_done) begin
        wait_cnt++;
        if (rv >= 0 && wait_cnt == rv + 1) begin
          bus_rvalid = 1'b1; bus_rdata = rdata;
        end
      end
      if (core_done) begin
        done_seen = 1'b1;
        chk("latency", 32'(c), 32'(exp_done));
        chk("rdata", core_rdata, exp_rd);
        chk("err", core_err, exp_err);
        chk("stall_in_done", core_stall, 0);
        core_req = 1'b0;
      end
    end
    chk("done_seen", done_seen, 1);
    chk("valid_cycles", 32'(valid_cnt), 32'(exp_valid));
    @(negedge clk);
    chk("done_one_cycle", core_done, 0);
    chk("rdata_hold", core_rdata, exp_rd);
    chk("err_hold", core_err, exp_err);
  endtask

  initial begin
    rst_n = 1'b0;
    core_req = 1'b0; core_we = 1'b0; core_addr = 32'h0; core_wdata = 32'h0;
    core_func3 = 3'b000; bus_ready = 1'b0; bus_rvalid = 1'b0; bus_rdata = 32'h0;
    #12;
    chk("rst_done", core_done, 0);
    chk("rst_valid", bus_valid, 0);
    chk("rst_rdata", core_rdata, 0);
    chk("rst_stall", core_stall, 0);
    @(negedge clk); rst_n = 1'b1;

    access(1'b1, 32'h100, 32'hDEADBEEF, 3'b010, 0, 0, 32'h0);
    access(1'b1, 32'h103, 32'h000000A5, 3'b000, 0, 0, 32'h0);
    access(1'b0, 32'h202, 32'h0, 3'b000, 0, 0, 32'h1280FF00);
    chk("lb_const", core_rdata, 32'hFFFFFF80);
    access(1'b0, 32'h202, 32'h0, 3'b101, 0, 0, 32'h1280FF00);
    chk("lhu_const", core_rdata, 32'h00001280);
    access(1'b0, 32'h102, 32'h0, 3'b010, 0, 0, 32'h0);
    access(1'b0, 32'h100, 32'h0, 3'b011, 0, 0, 32'h0);
    access(1'b1, 32'h101, 32'h1234, 3'b001, 0, 0, 32'h0);
    access(1'b0, 32'h104, 32'h0, 3'b101, 1, 1, 32'hCAFE8001);

    // Load timeout, then a late rvalid must be ignored
    access(1'b0, 32'h400, 32'h0, 3'b010, 0, -1, 32'h0);
    bus_rvalid = 1'b1; bus_rdata = 32'h5A5A5A5A;
    @(negedge clk);
    bus_rvalid = 1'b0;
    chk("late_rvalid_done", core_done, 0);
    chk("late_rvalid_rdata", core_rdata, 0);
    chk("late_rvalid_err", core_err, 1);
    access(1'b1, 32'h500, 32'h11223344, 3'b010, -1, 0, 32'h0);

    // Reset while waiting for a load response
    access(1'b0, 32'h204, 32'h0, 3'b010, 0, 0, 32'h87654321);
    @(posedge clk); #1;
    core_req = 1'b1; core_we = 1'b0; core_addr = 32'h300; core_func3 = 3'b010;
    @(negedge clk);
    @(negedge clk);
    chk("rst_test_req", bus_valid, 1);
    bus_ready = 1'b1;
    @(negedge clk);
    bus_ready = 1'b0;
    chk("rst_test_wait", bus_valid, 0);
    core_req = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_stall", core_stall, 0);
    chk("mid_rst_done", core_done, 0);
    chk("mid_rst_rdata", core_rdata, 0);
    chk("mid_rst_err", core_err, 0);
    chk("mid_rst_valid", bus_valid, 0);
    chk("mid_rst_fields", {bus_addr[31:2], bus_we, bus_wstrb}, 0);
    chk("mid_rst_wdata", bus_wdata, 0);
    @(negedge clk); rst_n = 1'b1;
    bus_rvalid = 1'b1; bus_rdata = 32'hFFFFFFFF;
    @(negedge clk);
    bus_rvalid = 1'b0;
    chk("post_rst_no_done", core_done, 0);
    @(negedge clk);
    chk("post_rst_no_done2", core_done, 0);
    access(1'b0, 32'h300, 32'h0, 3'b010, 0, 0, 32'h0BADF00D);

    for (int n = 0; n < 40; n++) begin
      bit we;
      logic [2:0] f3;
      logic [31:0] a;
      int rd, rv;
      we = 1'($urandom_range(0, 1));
      f3 = 3'($urandom_range(0, 7));
      a = $urandom;
      if ($urandom_range(0, 3) != 0) a[1:0] = a[1:0] & ~2'(m_size(f3) - 1);
      if (we) begin
        rd = $urandom_range(0, 2); rv = 0;
      end else begin
        rd = $urandom_range(0, 1); rv = (rd == 1) ? 0 : $urandom_range(0, 1);
      end
      access(we, a, $urandom, f3, rd, rv, $urandom);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
